// File: rtl/router_rx_port.sv
// rtl/router_rx_port.sv - router channel drain, byte-stream re-framer and packet checker
// Optional packet/error counters are built when ROUTER_RX_STATS_EN is defined.
module router_rx_port #(
  parameter logic [1:0] CH_ID     = 2'd0,
  parameter int         GAP_LIMIT = 16,
  parameter int         CNT_W     = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             vld_in,
  input  logic [7:0]       data_in,
  output logic             read_enb,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_err,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic             trunc,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int GW = $clog2(GAP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAY,
    S_PAR
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    rem_q, rem_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    par_q, par_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic          perr_q, perr_d;
  logic          aerr_q, aerr_d;
  logic          trunc_q, trunc_d;
  logic          inflight_q;

  logic [10:0]   mem_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    occ_q;
  logic [10:0]   head;

  logic          push, pop;
  logic          tag_sop, tag_eop, tag_err;

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_sop   = out_valid & head[8];
  assign out_eop   = out_valid & head[9];
  assign out_err   = out_valid & head[10];

  assign pop  = out_valid & out_ready;
  assign push = inflight_q;

  // A byte popped now lands next cycle; counting it ahead keeps the 2-deep buffer from overflowing.
  assign read_enb = resetn & vld_in &
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign pkt_done   = done_q;
  assign parity_err = perr_q;
  assign addr_err   = aerr_q;
  assign trunc      = trunc_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    par_d   = par_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    aerr_d  = 1'b0;
    trunc_d = 1'b0;
    tag_sop = 1'b0;
    tag_eop = 1'b0;
    tag_err = 1'b0;
    if (push) begin
      gap_d = '0;
      case (state_q)
        S_HDR: begin
          tag_sop = 1'b1;
          rem_d   = data_in[7:2];
          addr_d  = data_in[1:0];
          par_d   = data_in;
          state_d = (data_in[7:2] == 6'd0) ? S_PAR : S_PAY;
        end
        S_PAY: begin
          par_d = par_q ^ data_in;
          rem_d = rem_q - 6'd1;
          if (rem_q == 6'd1) begin
            state_d = S_PAR;
          end
        end
        S_PAR: begin
          tag_eop = 1'b1;
          perr_d  = (data_in != par_q);
          aerr_d  = (addr_q != CH_ID);
          tag_err = perr_d | aerr_d;
          done_d  = 1'b1;
          state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end else if ((state_q != S_HDR) && !vld_in) begin
      if (gap_q == GW'(GAP_LIMIT - 1)) begin
        trunc_d = 1'b1;
        gap_d   = '0;
        state_d = S_HDR;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_HDR;
      rem_q      <= '0;
      addr_q     <= '0;
      par_q      <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      aerr_q     <= 1'b0;
      trunc_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      par_q      <= par_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      aerr_q     <= aerr_d;
      trunc_q    <= trunc_d;
      inflight_q <= read_enb;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {tag_err, tag_eop, tag_sop, data_in};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef ROUTER_RX_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

  // A packet cannot both complete and time out in the same cycle, so one increment suffices.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (done_q) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
      if ((done_q & (perr_q | aerr_q)) | trunc_q) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule
